// File: rtl/opamp_offset_cal_pkg.sv
// Purpose : shared types and constants for the opamp offset-calibration SAR.
// Contents: FSM state enum, default parameter values, majority threshold helper.
package opamp_cal_pkg;

   localparam int unsigned TRIM_W_DEF  = 6;
   localparam int unsigned SETTLE_DEF  = 16;
   localparam int unsigned SAMPLES_DEF = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DECIDE,
      ST_DONE
   } state_t;

   // A bit is judged "too high" when the ones count strictly exceeds this value.
   function automatic int unsigned maj_thresh(input int unsigned samples);
      return samples / 2;
   endfunction

endpackage

// File: rtl/opamp_offset_cal_if.sv
// Purpose : pad-side control and opamp-side trim bundle of the offset calibrator.
// Signals : i_start, i_cmp_in, i_man_en, i_man_code (into the calibrator);
//           o_trim_code, o_cal_short, o_busy, o_done, o_cal_err (out of it).
// Modports: master = driver of the calibrator inputs, slave = the calibrator.
interface opamp_offset_cal_if
   import opamp_cal_pkg::*;
#(
   parameter int unsigned TRIM_W = TRIM_W_DEF
);

   logic              i_start;
   logic              i_cmp_in;
   logic              i_man_en;
   logic [TRIM_W-1:0] i_man_code;
   logic [TRIM_W-1:0] o_trim_code;
   logic              o_cal_short;
   logic              o_busy;
   logic              o_done;
   logic              o_cal_err;

   modport master (
      output i_start, i_cmp_in, i_man_en, i_man_code,
      input  o_trim_code, o_cal_short, o_busy, o_done, o_cal_err
   );

   modport slave (
      input  i_start, i_cmp_in, i_man_en, i_man_code,
      output o_trim_code, o_cal_short, o_busy, o_done, o_cal_err
   );

endinterface

// File: rtl/opamp_offset_cal_cmp_sync.sv
// Purpose : two-flop synchronizer for the asynchronous comparator output.
// Ports   : i_clk, i_rst (sync, active high, clears both flops),
//           i_d (async input), o_q (synchronized, 2-cycle latency).
module cmp_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/opamp_offset_cal.sv
// Purpose : successive-approximation offset calibration of the differential opamp.
//           Shorts the opamp inputs, settles, majority-votes the synchronized
//           comparator per bit and binary-searches the trim code MSB first.
// Ports   : i_clk, i_rst (sync, active high);
//           bus (slave): start/cmp/manual-override inputs, trim code, short,
//           busy, done pulse and sticky saturation error outputs.
module opamp_offset_cal
   import opamp_cal_pkg::*;
#(
   parameter int unsigned TRIM_W        = TRIM_W_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_DEF,
   parameter int unsigned SAMPLES       = SAMPLES_DEF
) (
   input logic               i_clk,
   input logic               i_rst,
   opamp_offset_cal_if.slave bus
);

   localparam int unsigned IDX_W  = $clog2(TRIM_W);
   localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES);
   localparam int unsigned ONES_W = $clog2(SAMPLES + 1);
   localparam int unsigned SMP_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

   localparam logic [TRIM_W-1:0] CODE_MID = TRIM_W'(1) << (TRIM_W - 1);
   localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(TRIM_W - 1);
   localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [SMP_W-1:0]  SMP_LOAD = SMP_W'(SAMPLES - 1);
   localparam logic [ONES_W-1:0] MAJ_TH   = ONES_W'(maj_thresh(SAMPLES));

   state_t            r_state;
   logic [TRIM_W-1:0] r_code_q;
   logic [IDX_W-1:0]  r_idx;
   logic [SET_W-1:0]  r_set_cnt;
   logic [SMP_W-1:0]  r_smp_cnt;
   logic [ONES_W-1:0] r_ones;
   logic              r_busy;
   logic              r_short;
   logic              r_done;
   logic              r_err;

   logic              w_cmp_s;
   logic [TRIM_W-1:0] w_code_dec;
   logic              w_last;

   cmp_sync u_cmp_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (bus.i_cmp_in),
      .o_q   (w_cmp_s)
   );

   // Trial code after the current bit decision: resolve bit idx, arm bit idx-1.
   always_comb begin
      w_code_dec = r_code_q;
      w_last     = (r_idx == '0);
      if (r_ones > MAJ_TH) begin
         w_code_dec[r_idx] = 1'b0;
      end
      if (!w_last) begin
         w_code_dec[r_idx - IDX_W'(1)] = 1'b1;
      end
   end

   // SAR sequencer with registered status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_code_q  <= CODE_MID;
         r_idx     <= IDX_MSB;
         r_set_cnt <= SET_LOAD;
         r_smp_cnt <= SMP_LOAD;
         r_ones    <= '0;
         r_busy    <= 1'b0;
         r_short   <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.i_start && !bus.i_man_en) begin
                  r_state   <= ST_SETTLE;
                  r_code_q  <= CODE_MID;
                  r_idx     <= IDX_MSB;
                  r_set_cnt <= SET_LOAD;
                  r_ones    <= '0;
                  r_err     <= 1'b0;
                  r_busy    <= 1'b1;
                  r_short   <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (r_set_cnt == '0) begin
                  r_state   <= ST_SAMPLE;
                  r_smp_cnt <= SMP_LOAD;
               end else begin
                  r_set_cnt <= r_set_cnt - SET_W'(1);
               end
            end
            ST_SAMPLE: begin
               r_ones <= r_ones + ONES_W'(w_cmp_s);
               if (r_smp_cnt == '0) begin
                  r_state <= ST_DECIDE;
               end else begin
                  r_smp_cnt <= r_smp_cnt - SMP_W'(1);
               end
            end
            ST_DECIDE: begin
               r_code_q <= w_code_dec;
               if (w_last) begin
                  // Error flag is published together with the done pulse.
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_short <= 1'b0;
                  r_err   <= (w_code_dec == '0) || (w_code_dec == '1);
               end else begin
                  r_state   <= ST_SETTLE;
                  r_idx     <= r_idx - IDX_W'(1);
                  r_ones    <= '0;
                  r_set_cnt <= SET_LOAD;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Manual override reaches the trim switches with no register in the path.
   assign bus.o_trim_code = bus.i_man_en ? bus.i_man_code : r_code_q;
   assign bus.o_cal_short = r_short;
   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_cal_err   = r_err;

endmodule

// File: tb/tb_opamp_offset_cal.sv
// Purpose : self-checking bench for opamp_offset_cal (default parameters).
// Cycle n is the period after the n-th rising edge counted from the start
// cycle; inputs change and outputs are checked on the falling edge.
module tb_opamp_offset_cal;
   import opamp_cal_pkg::*;

   localparam int unsigned TW = 6;

   typedef struct {
      int         thr;
      logic [5:0] code;
      logic       err;
      int         mode;
   } vec_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   int   cyc;
   int   model_thr;
   bit   pat_mode;
   logic pat [0:63];
   vec_t vecs [0:7];

   opamp_offset_cal_if #(.TRIM_W(TW)) bus ();

   opamp_offset_cal #(
      .TRIM_W        (TW),
      .SETTLE_CYCLES (16),
      .SAMPLES       (3)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Comparator model: a threshold on the live trim code, or a per-cycle pattern.
   task automatic drive_cmp();
      if (pat_mode) bus.i_cmp_in = (cyc >= 0 && cyc < 64) ? pat[cyc] : 1'b0;
      else          bus.i_cmp_in = (int'(bus.o_trim_code) >= model_thr);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      drive_cmp();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // mode 0: single start pulse; 1: extra pulse at cycle 30; 2: start held high.
   task automatic run_cal(input int thr, input logic [5:0] exp_code,
                          input logic exp_err, input int mode);
      logic exp_busy;
      model_thr = thr;
      pat_mode  = 1'b0;
      @(negedge clk);
      cyc = 0;
      drive_cmp();
      bus.i_start = 1'b1;
      for (int c = 1; c <= 124; c++) begin
         tick();
         bus.i_start = (mode == 2) || (mode == 1 && c == 30);
         exp_busy = (c <= 120) || (mode == 2 && c >= 123);
         chk("busy", 8'(bus.o_busy), 8'(exp_busy));
         chk("cal_short", 8'(bus.o_cal_short), 8'(exp_busy));
         chk("done", 8'(bus.o_done), 8'(c == 121));
         if (c == 1) chk("err_clr_on_start", 8'(bus.o_cal_err), 8'h00);
         if (c == 121) begin
            chk("code_at_done", 8'(bus.o_trim_code), 8'(exp_code));
            chk("err_at_done", 8'(bus.o_cal_err), 8'(exp_err));
         end
         if (c == 124 && mode != 2) begin
            chk("code_held", 8'(bus.o_trim_code), 8'(exp_code));
            chk("err_sticky", 8'(bus.o_cal_err), 8'(exp_err));
         end
         if (c == 123 && mode == 2) chk("err_clr_restart", 8'(bus.o_cal_err), 8'h00);
      end
      bus.i_start = 1'b0;
   endtask

   // Synced samples p[2],p[1],p[0] land in SAMPLE cycles 17..19 from cmp_in in 15..17.
   task automatic maj_test(input logic [2:0] p, input logic other, input logic [5:0] exp_code);
      pat_mode = 1'b1;
      for (int i = 0; i < 64; i++) pat[i] = other;
      pat[15] = p[2];
      pat[16] = p[1];
      pat[17] = p[0];
      @(negedge clk);
      cyc = 0;
      drive_cmp();
      bus.i_start = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         tick();
         bus.i_start = 1'b0;
         if (c == 21) chk("maj_code", 8'(bus.o_trim_code), 8'(exp_code));
      end
      pat_mode = 1'b0;
      do_reset();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      cyc = 0;
      model_thr = 43;
      pat_mode = 1'b0;
      rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_cmp_in = 1'b0;
      bus.i_man_en = 1'b0;
      bus.i_man_code = '0;

      vecs[0] = '{thr: 43, code: 6'h2A, err: 1'b0, mode: 0};
      vecs[1] = '{thr: 0,  code: 6'h00, err: 1'b1, mode: 0};
      vecs[2] = '{thr: 20, code: 6'h13, err: 1'b0, mode: 1};
      vecs[3] = '{thr: 64, code: 6'h3F, err: 1'b1, mode: 0};
      vecs[4] = '{thr: 1,  code: 6'h00, err: 1'b1, mode: 0};
      vecs[5] = '{thr: 63, code: 6'h3E, err: 1'b0, mode: 0};
      vecs[6] = '{thr: 33, code: 6'h20, err: 1'b0, mode: 1};
      vecs[7] = '{thr: 0,  code: 6'h00, err: 1'b1, mode: 2};

      // Reset values.
      do_reset();
      chk("rst_trim", 8'(bus.o_trim_code), 8'h20);
      chk("rst_busy", 8'(bus.o_busy), 8'h00);
      chk("rst_done", 8'(bus.o_done), 8'h00);
      chk("rst_short", 8'(bus.o_cal_short), 8'h00);
      chk("rst_err", 8'(bus.o_cal_err), 8'h00);

      // Full calibrations from the vector table.
      for (int v = 0; v < 8; v++) begin
         run_cal(vecs[v].thr, vecs[v].code, vecs[v].err, vecs[v].mode);
         if (vecs[v].mode == 2) do_reset();
      end

      // Majority vote on the MSB.
      maj_test(3'b101, 1'b0, 6'h10);
      maj_test(3'b010, 1'b1, 6'h30);

      // Abort by reset at cycle 50, start re-pulsed at cycle 30 ignored.
      model_thr = 43;
      @(negedge clk);
      cyc = 0;
      drive_cmp();
      bus.i_start = 1'b1;
      for (int c = 1; c <= 135; c++) begin
         tick();
         bus.i_start = (c == 30);
         rst = (c == 50);
         if (c == 31) chk("busy_after_restart_pulse", 8'(bus.o_busy), 8'h01);
         if (c == 51) begin
            chk("abort_trim", 8'(bus.o_trim_code), 8'h20);
            chk("abort_short", 8'(bus.o_cal_short), 8'h00);
            chk("abort_err", 8'(bus.o_cal_err), 8'h00);
         end
         if (c >= 51) begin
            chk("abort_busy", 8'(bus.o_busy), 8'h00);
            chk("abort_no_done", 8'(bus.o_done), 8'h00);
         end
      end
      run_cal(43, 6'h2A, 1'b0, 0);

      // Manual override while idle.
      do_reset();
      @(negedge clk);
      bus.i_man_en = 1'b1;
      bus.i_man_code = 6'h11;
      #1;
      chk("man_trim", 8'(bus.o_trim_code), 8'h11);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk("man_start_ignored", 8'(bus.o_busy), 8'h00);
      tick();
      chk("man_start_ignored2", 8'(bus.o_busy), 8'h00);
      bus.i_man_en = 1'b0;
      #1;
      chk("man_release", 8'(bus.o_trim_code), 8'h20);

      // Manual override mid-calibration: output overridden, SAR continues.
      model_thr = 0;
      @(negedge clk);
      cyc = 0;
      drive_cmp();
      bus.i_start = 1'b1;
      for (int c = 1; c <= 122; c++) begin
         tick();
         bus.i_start = 1'b0;
         if (c == 40) begin
            bus.i_man_en = 1'b1;
            bus.i_man_code = 6'h15;
            #1;
            chk("mid_man_trim", 8'(bus.o_trim_code), 8'h15);
            chk("mid_man_busy", 8'(bus.o_busy), 8'h01);
         end
         if (c == 121) begin
            chk("mid_man_done", 8'(bus.o_done), 8'h01);
            chk("mid_man_trim_done", 8'(bus.o_trim_code), 8'h15);
         end
      end
      bus.i_man_en = 1'b0;
      #1;
      chk("mid_man_code_q", 8'(bus.o_trim_code), 8'h00);
      chk("mid_man_err", 8'(bus.o_cal_err), 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
